// File: rtl/cla_adder.sv
// cla_adder: registered 5-bit unsigned adder.
// Operands are registered, summed by a flat carry-lookahead core, and the
// 5-bit sum plus carry-out are registered again (2-edge latency, 1 add/clk).
module cla_adder (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] a,
   input  logic [4:0] b,
   output logic [4:0] sum,
   output logic       cout
);

   localparam int W = 5;

   logic [W-1:0] a_q, b_q;
   logic [W-1:0] g, p;
   logic [W:0]   c;
   logic [W-1:0] s;

   // Stage 1: capture operands; reset clears them so the first
   // post-reset result reads as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         a_q <= a;
         b_q <= b;
      end
   end

   // Per-bit generate and propagate.
   always_comb begin
      g = a_q & b_q;
      p = a_q ^ b_q;
   end

   // Flat lookahead carries: each c[i] is a sum-of-products of g, p and
   // c[0] only, never of an earlier c[i], so there is no ripple path.
   always_comb begin
      logic term;
      c    = '0;
      term = 1'b0;
      c[0] = 1'b0;
      for (int i = 1; i <= W; i++) begin
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int k = j + 1; k < i; k++) term = term & p[k];
            c[i] = c[i] | term;
         end
         term = c[0];
         for (int k = 0; k < i; k++) term = term & p[k];
         c[i] = c[i] | term;
      end
   end

   // Sum bits from propagate and lookahead carries.
   always_comb s = p ^ c[W-1:0];

   // Stage 2: register the result; reset takes priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
      end else begin
         sum  <= s;
         cout <= c[W];
      end
   end

endmodule

// File: tb/tb_cla_adder.sv
// tb_cla_adder: directed-vector and exhaustive check of cla_adder.
// Inputs change and outputs are sampled on the falling edge; a result is
// expected two falling edges after its operands were driven.
module tb_cla_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] a, b;
   logic [4:0] sum;
   logic       cout;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [4:0] s;
      logic       c;
      string      nm;
   } exp_t;

   typedef struct {
      logic [4:0] a;
      logic [4:0] b;
      logic [4:0] s;
      logic       c;
   } vec_t;

   exp_t q[$];

   cla_adder dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .sum  (sum),
      .cout (cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input exp_t e);
      n_chk++;
      if (sum !== e.s || cout !== e.c) begin
         n_fail++;
         $display("FAIL %s: got sum=%b cout=%b, want sum=%b cout=%b",
                  e.nm, sum, cout, e.s, e.c);
      end
   endtask

   // One cycle: check the result due now, then drive a new pair.
   task automatic step(input logic [4:0] va, input logic [4:0] vb,
                       input logic [4:0] es, input logic ec, input string nm);
      exp_t e;
      @(negedge clk);
      if (q.size() == 2) chk(q.pop_front());
      rst = 1'b0;
      a = va;
      b = vb;
      e.s = es; e.c = ec; e.nm = nm;
      q.push_back(e);
   endtask

   // One reset cycle mid-stream: in-flight pairs are discarded and the
   // next two samples must read zero.
   task automatic reset_pulse();
      exp_t z;
      @(negedge clk);
      if (q.size() == 2) chk(q.pop_front());
      rst = 1'b1;
      q.delete();
      z.s = '0; z.c = 1'b0; z.nm = "mid_rst_in";
      q.push_back(z);
      z.nm = "mid_rst_after";
      q.push_back(z);
   endtask

   // Check remaining results without driving new pairs.
   task automatic drain();
      while (q.size() > 0) begin
         @(negedge clk);
         chk(q.pop_front());
      end
   endtask

   initial begin
      vec_t tbl[6];
      exp_t e;
      int   rst_at;

      tbl[0] = '{5'd0,  5'd0,  5'b00000, 1'b0};
      tbl[1] = '{5'd1,  5'd1,  5'b00010, 1'b0};
      tbl[2] = '{5'd2,  5'd27, 5'b11101, 1'b0};
      tbl[3] = '{5'd31, 5'd1,  5'b00000, 1'b1};
      tbl[4] = '{5'd21, 5'd13, 5'b00010, 1'b1};
      tbl[5] = '{5'd31, 5'd31, 5'b11110, 1'b1};

      // Reset held for two edges with nonzero operands present.
      rst = 1'b1;
      a = 5'b10101;
      b = 5'b01101;
      @(negedge clk);
      e.s = '0; e.c = 1'b0; e.nm = "rst_edge1";
      chk(e);
      @(negedge clk);
      e.nm = "rst_edge2";
      chk(e);

      // Release: first sample is the cleared stage-1 result, then 21+13.
      rst = 1'b0;
      e.nm = "post_release_zero";
      q.push_back(e);
      e.s = 5'b00010; e.c = 1'b1; e.nm = "post_release_21p13";
      q.push_back(e);

      // Directed vectors streamed back-to-back.
      foreach (tbl[i])
         step(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, $sformatf("vec%0d", i));
      // Same sequence again back-to-back to catch skips/duplicates.
      foreach (tbl[i])
         step(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, $sformatf("pipe%0d", i));
      drain();

      // Exhaustive stream with one reset pulse at a random point.
      rst_at = $urandom_range(100, 900);
      for (int i = 0; i < 1024; i++) begin
         logic [5:0] r;
         if (i == rst_at) reset_pulse();
         r = 6'(i[9:5]) + 6'(i[4:0]);
         step(i[9:5], i[4:0], r[4:0], r[5], $sformatf("exh_%0d_%0d", i[9:5], i[4:0]));
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, want finish before 200000");
      $fatal(1);
   end

endmodule
